// File: rtl/fpnew_issue_rob.sv
// Issue-side reorder buffer for the FPU: tags each issued op with a slot index,
// gathers out-of-order tagged results and writes them back to the core in issue order.
module fpnew_issue_rob #(
   parameter  int Width     = 64,
   parameter  int Depth     = 4,
   parameter  int CtrlWidth = 16,
   localparam int TagWidth  = $clog2(Depth)
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   req_valid_i,
   output logic                   req_ready_o,
   input  logic [3*Width-1:0]     req_operands_i,
   input  logic [CtrlWidth-1:0]   req_ctrl_i,
   input  logic [4:0]             req_rd_i,
   output logic                   fpu_valid_o,
   input  logic                   fpu_ready_i,
   output logic [3*Width-1:0]     fpu_operands_o,
   output logic [CtrlWidth-1:0]   fpu_ctrl_o,
   output logic [TagWidth-1:0]    fpu_tag_o,
   input  logic                   fpu_rsp_valid_i,
   output logic                   fpu_rsp_ready_o,
   input  logic [Width-1:0]       fpu_result_i,
   input  logic [4:0]             fpu_status_i,
   input  logic [TagWidth-1:0]    fpu_tag_i,
   output logic                   wb_valid_o,
   input  logic                   wb_ready_i,
   output logic [4:0]             wb_rd_o,
   output logic [Width-1:0]       wb_result_o,
   output logic [4:0]             wb_status_o,
   input  logic                   flush_i,
   output logic                   fpu_flush_o,
   output logic                   busy_o,
   output logic                   err_o
);

   localparam logic [TagWidth:0]   FullCnt = (TagWidth+1)'(Depth);
   localparam logic [TagWidth-1:0] TagOne  = TagWidth'(1);

   logic [Depth-1:0]    alloc_q, done_q;
   logic [4:0]          rd_q     [Depth];
   logic [Width-1:0]    result_q [Depth];
   logic [4:0]          status_q [Depth];
   logic [TagWidth-1:0] head_q, tail_q;
   logic [TagWidth:0]   count_q;
   logic                err_q;

   logic full, issue_ok, issue_fire, rsp_live, rsp_accept, rsp_bogus, retire;

   // Full is judged on registered count only, so a same-cycle retire never frees a slot early.
   assign full       = (count_q == FullCnt);
   assign issue_ok   = ~full & ~flush_i & ~rst_i;
   assign fpu_valid_o = req_valid_i & issue_ok;
   assign req_ready_o = fpu_ready_i & issue_ok;
   assign issue_fire = req_valid_i & req_ready_o;

   assign fpu_operands_o = req_operands_i;
   assign fpu_ctrl_o     = req_ctrl_i;
   assign fpu_tag_o      = tail_q;

   assign fpu_rsp_ready_o = 1'b1;
   assign rsp_live   = fpu_rsp_valid_i & ~flush_i & ~rst_i;
   assign rsp_accept = rsp_live & alloc_q[fpu_tag_i] & ~done_q[fpu_tag_i];
   assign rsp_bogus  = rsp_live & ~(alloc_q[fpu_tag_i] & ~done_q[fpu_tag_i]);

   assign wb_valid_o  = alloc_q[head_q] & done_q[head_q];
   assign wb_rd_o     = rd_q[head_q];
   assign wb_result_o = result_q[head_q];
   assign wb_status_o = status_q[head_q];
   assign retire      = wb_valid_o & wb_ready_i;

   assign fpu_flush_o = flush_i;
   assign busy_o      = (count_q != '0);
   assign err_o       = err_q;

   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
         alloc_q <= '0;
         done_q  <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         if (rst_i) err_q <= 1'b0;
      end else begin
         // tail==head with head allocated means full, so issue and retire never hit one slot.
         if (issue_fire) begin
            alloc_q[tail_q] <= 1'b1;
            done_q[tail_q]  <= 1'b0;
            tail_q          <= tail_q + TagOne;
         end
         if (rsp_accept) done_q[fpu_tag_i] <= 1'b1;
         if (rsp_bogus)  err_q <= 1'b1;
         if (retire) begin
            alloc_q[head_q] <= 1'b0;
            head_q          <= head_q + TagOne;
         end
         if (issue_fire && !retire)      count_q <= count_q + 1'b1;
         else if (!issue_fire && retire) count_q <= count_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (issue_fire) rd_q[tail_q] <= req_rd_i;
      if (rsp_accept) begin
         result_q[fpu_tag_i] <= fpu_result_i;
         status_q[fpu_tag_i] <= fpu_status_i;
      end
   end

endmodule

// File: tb/tb_fpnew_issue_rob.sv
// Directed bench for fpnew_issue_rob: in-order writeback, full, backpressure, wrap, flush, error.
module tb_fpnew_issue_rob;

   logic          clk = 1'b0;
   logic          rst_i;
   logic          req_valid_i;
   logic          req_ready_o;
   logic [191:0]  req_operands_i;
   logic [15:0]   req_ctrl_i;
   logic [4:0]    req_rd_i;
   logic          fpu_valid_o;
   logic          fpu_ready_i;
   logic [191:0]  fpu_operands_o;
   logic [15:0]   fpu_ctrl_o;
   logic [1:0]    fpu_tag_o;
   logic          fpu_rsp_valid_i;
   logic          fpu_rsp_ready_o;
   logic [63:0]   fpu_result_i;
   logic [4:0]    fpu_status_i;
   logic [1:0]    fpu_tag_i;
   logic          wb_valid_o;
   logic          wb_ready_i;
   logic [4:0]    wb_rd_o;
   logic [63:0]   wb_result_o;
   logic [4:0]    wb_status_o;
   logic          flush_i;
   logic          fpu_flush_o;
   logic          busy_o;
   logic          err_o;

   int checks = 0;
   int errors = 0;

   fpnew_issue_rob #(.Width(64), .Depth(4), .CtrlWidth(16)) dut (
      .clk_i(clk), .rst_i(rst_i),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req_operands_i(req_operands_i), .req_ctrl_i(req_ctrl_i), .req_rd_i(req_rd_i),
      .fpu_valid_o(fpu_valid_o), .fpu_ready_i(fpu_ready_i),
      .fpu_operands_o(fpu_operands_o), .fpu_ctrl_o(fpu_ctrl_o), .fpu_tag_o(fpu_tag_o),
      .fpu_rsp_valid_i(fpu_rsp_valid_i), .fpu_rsp_ready_o(fpu_rsp_ready_o),
      .fpu_result_i(fpu_result_i), .fpu_status_i(fpu_status_i), .fpu_tag_i(fpu_tag_i),
      .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_rd_o(wb_rd_o),
      .wb_result_o(wb_result_o), .wb_status_o(wb_status_o),
      .flush_i(flush_i), .fpu_flush_o(fpu_flush_o), .busy_o(busy_o), .err_o(err_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      tick();
      tick();
      rst_i = 1'b0;
   endtask

   task automatic issue(input logic [4:0] rd, input logic [1:0] exp_tag);
      req_valid_i    = 1'b1;
      req_rd_i       = rd;
      req_operands_i = {64'h1111_0000_0000_0000 + 64'(rd), 64'h2222_0000_0000_0000 + 64'(rd),
                        64'h3333_0000_0000_0000 + 64'(rd)};
      req_ctrl_i     = 16'hA500 | 16'(rd);
      fpu_ready_i    = 1'b1;
      #1;
      chk("issue_fpu_valid", 64'(fpu_valid_o), 64'd1);
      chk("issue_req_ready", 64'(req_ready_o), 64'd1);
      chk("issue_tag", 64'(fpu_tag_o), 64'(exp_tag));
      tick();
      req_valid_i = 1'b0;
   endtask

   task automatic respond(input logic [1:0] tag, input logic [63:0] res, input logic [4:0] st);
      fpu_rsp_valid_i = 1'b1;
      fpu_tag_i       = tag;
      fpu_result_i    = res;
      fpu_status_i    = st;
      tick();
      fpu_rsp_valid_i = 1'b0;
   endtask

   initial begin
      rst_i = 1'b1; req_valid_i = 1'b1; fpu_ready_i = 1'b1; req_rd_i = '0;
      req_operands_i = '0; req_ctrl_i = '0; fpu_rsp_valid_i = 1'b0; fpu_result_i = '0;
      fpu_status_i = '0; fpu_tag_i = '0; wb_ready_i = 1'b0; flush_i = 1'b0;

      // Reset behaviour
      #1;
      chk("rst_req_ready", 64'(req_ready_o), 64'd0);
      chk("rst_fpu_valid", 64'(fpu_valid_o), 64'd0);
      tick();
      tick();
      rst_i = 1'b0; req_valid_i = 1'b0;
      #1;
      chk("rst_wb_valid", 64'(wb_valid_o), 64'd0);
      chk("rst_busy", 64'(busy_o), 64'd0);
      chk("rst_err", 64'(err_o), 64'd0);
      chk("rst_rsp_ready", 64'(fpu_rsp_ready_o), 64'd1);
      chk("rst_tag", 64'(fpu_tag_o), 64'd0);

      // Single op with combinational pass-through
      req_valid_i = 1'b1; req_rd_i = 5'd5;
      req_operands_i = {64'hAAAA_BBBB_CCCC_DDDD, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210};
      req_ctrl_i = 16'h5A3C;
      #1;
      chk("pass_op_lo", fpu_operands_o[63:0], 64'hFEDC_BA98_7654_3210);
      chk("pass_op_hi", fpu_operands_o[191:128], 64'hAAAA_BBBB_CCCC_DDDD);
      chk("pass_ctrl", 64'(fpu_ctrl_o), 64'h5A3C);
      chk("single_tag", 64'(fpu_tag_o), 64'd0);
      tick();
      req_valid_i = 1'b0;
      chk("single_busy", 64'(busy_o), 64'd1);
      chk("single_no_wb", 64'(wb_valid_o), 64'd0);
      fpu_rsp_valid_i = 1'b1; fpu_tag_i = 2'd0;
      fpu_result_i = 64'h3FF0_0000_0000_0000; fpu_status_i = 5'd0;
      #1;
      chk("single_no_bypass", 64'(wb_valid_o), 64'd0);
      tick();
      fpu_rsp_valid_i = 1'b0;
      chk("single_wb_valid", 64'(wb_valid_o), 64'd1);
      chk("single_wb_rd", 64'(wb_rd_o), 64'd5);
      chk("single_wb_result", wb_result_o, 64'h3FF0_0000_0000_0000);
      chk("single_wb_status", 64'(wb_status_o), 64'd0);
      wb_ready_i = 1'b1;
      tick();
      wb_ready_i = 1'b0;
      chk("single_busy_off", 64'(busy_o), 64'd0);
      chk("single_wb_off", 64'(wb_valid_o), 64'd0);

      // Out-of-order return, in-order writeback
      do_reset();
      wb_ready_i = 1'b1;
      issue(5'd5, 2'd0);
      issue(5'd6, 2'd1);
      respond(2'd1, 64'h4000_0000_0000_0000, 5'h01);
      chk("ooo_wait0", 64'(wb_valid_o), 64'd0);
      tick();
      chk("ooo_wait1", 64'(wb_valid_o), 64'd0);
      tick();
      chk("ooo_wait2", 64'(wb_valid_o), 64'd0);
      respond(2'd0, 64'h4008_0000_0000_0000, 5'h10);
      chk("ooo_first_valid", 64'(wb_valid_o), 64'd1);
      chk("ooo_first_rd", 64'(wb_rd_o), 64'd5);
      chk("ooo_first_result", wb_result_o, 64'h4008_0000_0000_0000);
      chk("ooo_first_status", 64'(wb_status_o), 64'h10);
      tick();
      chk("ooo_second_valid", 64'(wb_valid_o), 64'd1);
      chk("ooo_second_rd", 64'(wb_rd_o), 64'd6);
      chk("ooo_second_result", wb_result_o, 64'h4000_0000_0000_0000);
      chk("ooo_second_status", 64'(wb_status_o), 64'h01);
      tick();
      chk("ooo_done_valid", 64'(wb_valid_o), 64'd0);
      chk("ooo_done_busy", 64'(busy_o), 64'd0);
      wb_ready_i = 1'b0;

      // Full: same-cycle retire does not admit the fifth op
      do_reset();
      issue(5'd1, 2'd0);
      issue(5'd2, 2'd1);
      issue(5'd3, 2'd2);
      issue(5'd4, 2'd3);
      respond(2'd0, 64'h11, 5'h0);
      req_valid_i = 1'b1; req_rd_i = 5'd9; fpu_ready_i = 1'b1; wb_ready_i = 1'b1;
      #1;
      chk("full_wb_head", 64'(wb_valid_o), 64'd1);
      chk("full_req_ready", 64'(req_ready_o), 64'd0);
      chk("full_fpu_valid", 64'(fpu_valid_o), 64'd0);
      tick();
      wb_ready_i = 1'b0;
      chk("full_after_ready", 64'(req_ready_o), 64'd1);
      chk("full_after_valid", 64'(fpu_valid_o), 64'd1);
      chk("full_after_tag", 64'(fpu_tag_o), 64'd0);
      tick();
      req_valid_i = 1'b0;
      chk("full_again_ready", 64'(req_ready_o), 64'd0);
      chk("full_busy", 64'(busy_o), 64'd1);

      // Backpressure holds writeback outputs stable
      do_reset();
      issue(5'd7, 2'd0);
      respond(2'd0, 64'hC0DE_0000_1234_5678, 5'h03);
      for (int i = 0; i < 5; i++) begin
         chk("bp_valid", 64'(wb_valid_o), 64'd1);
         chk("bp_rd", 64'(wb_rd_o), 64'd7);
         chk("bp_result", wb_result_o, 64'hC0DE_0000_1234_5678);
         chk("bp_status", 64'(wb_status_o), 64'h03);
         tick();
      end
      wb_ready_i = 1'b1;
      tick();
      wb_ready_i = 1'b0;
      chk("bp_released", 64'(wb_valid_o), 64'd0);

      // Ten ops, pairs returned in reverse, tags wrap 0..3
      do_reset();
      for (int p = 0; p < 5; p++) begin
         issue(5'(10 + 2*p), 2'(2*p));
         issue(5'(11 + 2*p), 2'(2*p + 1));
         respond(2'(2*p + 1), 64'(200 + 2*p + 1), 5'h0);
         chk("wrap_hold", 64'(wb_valid_o), 64'd0);
         respond(2'(2*p), 64'(200 + 2*p), 5'h0);
         wb_ready_i = 1'b1;
         chk("wrap_rd_a", 64'(wb_rd_o), 64'(10 + 2*p));
         chk("wrap_res_a", wb_result_o, 64'(200 + 2*p));
         tick();
         chk("wrap_rd_b", 64'(wb_rd_o), 64'(11 + 2*p));
         chk("wrap_res_b", wb_result_o, 64'(200 + 2*p + 1));
         tick();
         wb_ready_i = 1'b0;
         chk("wrap_empty", 64'(busy_o), 64'd0);
      end

      // Flush with a response and request in the same cycle
      do_reset();
      issue(5'd1, 2'd0);
      issue(5'd2, 2'd1);
      issue(5'd3, 2'd2);
      flush_i = 1'b1; fpu_rsp_valid_i = 1'b1; fpu_tag_i = 2'd0; fpu_result_i = 64'h99;
      req_valid_i = 1'b1; req_rd_i = 5'd4;
      #1;
      chk("flush_out", 64'(fpu_flush_o), 64'd1);
      chk("flush_no_issue", 64'(fpu_valid_o), 64'd0);
      chk("flush_no_ready", 64'(req_ready_o), 64'd0);
      tick();
      flush_i = 1'b0; fpu_rsp_valid_i = 1'b0; req_valid_i = 1'b0;
      chk("flush_busy", 64'(busy_o), 64'd0);
      chk("flush_no_wb", 64'(wb_valid_o), 64'd0);
      chk("flush_flush_low", 64'(fpu_flush_o), 64'd0);
      chk("flush_err_clean", 64'(err_o), 64'd0);
      issue(5'd8, 2'd0);
      chk("flush_reissue_busy", 64'(busy_o), 64'd1);

      // Bogus tag sets a sticky error cleared only by reset
      respond(2'd2, 64'h0, 5'h0);
      chk("bogus_err", 64'(err_o), 64'd1);
      chk("bogus_no_wb", 64'(wb_valid_o), 64'd0);
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
      chk("bogus_err_flush", 64'(err_o), 64'd1);
      chk("bogus_busy_flush", 64'(busy_o), 64'd0);
      do_reset();
      #1;
      chk("bogus_err_reset", 64'(err_o), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fpnew_issue_rob.md
# fpnew_issue_rob

Requester-side companion to the FPU top level. It accepts FP operations from the core, issues them to the FPU with a tag naming a reorder-buffer slot, and collects tagged results that return out of order across operation groups. It writes results back to the core strictly in issue order. It sits between the core's FP dispatch stage and the FPU's input/output handshakes, and forwards flush.

## Interface
- Width, 64, operand/result width; must equal the FPU width.
- Depth, 4, reorder entries; power of two, ≥2.
- CtrlWidth, 16, opaque packed op control (rnd_mode, op, op_mod, src/dst/int fmt, vectorial); passed through unchanged.
- TagWidth, $clog2(Depth), derived; not overridable.

- clk_i  in  1  clock
- rst_i  in  1  reset; one clock; reset is synchronous and active-high
- req_valid_i  in  1  core request valid
- req_ready_o  out  1  request accepted when valid&ready
- req_operands_i  in  3×Width  operands
- req_ctrl_i  in  CtrlWidth  op control
- req_rd_i  in  5  destination register id
- fpu_valid_o  out  1  to FPU in_valid
- fpu_ready_i  in  1  from FPU in_ready
- fpu_operands_o  out  3×Width  to FPU
- fpu_ctrl_o  out  CtrlWidth  to FPU
- fpu_tag_o  out  TagWidth  slot index issued as FPU tag
- fpu_rsp_valid_i  in  1  FPU out_valid
- fpu_rsp_ready_o  out  1  FPU out_ready; constant 1
- fpu_result_i  in  Width  FPU result
- fpu_status_i  in  5  fflags NV,DZ,OF,UF,NX
- fpu_tag_i  in  TagWidth  returned tag
- wb_valid_o  out  1  in-order writeback valid
- wb_ready_i  in  1  writeback ready
- wb_rd_o  out  5  destination id
- wb_result_o  out  Width  result
- wb_status_o  out  5  fflags
- flush_i  in  1  kill all in-flight ops
- fpu_flush_o  out  1  equals flush_i (combinational)
- busy_o  out  1  any entry allocated
- err_o  out  1  sticky: response with invalid tag

## Operation
- State: Depth entries {alloc, done, rd, result, status}; head, tail pointers (TagWidth, wrap mod Depth); count (TagWidth+1 bits).
- Issue: fpu_valid_o = req_valid_i & ~full & ~flush_i & ~rst_i; req_ready_o = fpu_ready_i & ~full & ~flush_i & ~rst_i. Operands/ctrl pass through combinationally; fpu_tag_o = tail. No path from ready to valid.
- On issue handshake: entry[tail] ← alloc=1, done=0, rd=req_rd_i; tail+1.
- Response: fpu_rsp_ready_o=1 always (slot pre-reserved). On fpu_rsp_valid_i: if entry[fpu_tag_i].alloc & ~done → store result/status, done=1; otherwise drop and set err_o.
- Writeback: wb_valid_o = entry[head].alloc & entry[head].done; wb_* read from entry[head]. On wb handshake: entry[head].alloc=0, head+1.
- full = (count==Depth). Issue blocked when full even if retire occurs same cycle. Simultaneous issue and retire: count unchanged.
- Response for head entry in cycle N: wb_valid_o high in N+1 (no bypass).
- Flush (flush_i=1): next cycle all alloc/done=0, head=tail=count=0. Responses and issues in the flush cycle are discarded. err_o is not cleared.
- Reset: same as flush, plus err_o=0.

## Timing
- Reset values: req_ready_o=0, fpu_valid_o=0 while rst_i; after reset wb_valid_o=0, busy_o=0, err_o=0, fpu_rsp_ready_o=1, tail=0.
- Issue: 0 cycles added (combinational pass-through).
- Response to writeback: 1 cycle minimum; held while wb_ready_i=0. wb_* are stable while wb_valid_o & ~wb_ready_i.
- busy_o = count≠0, registered-state derived.
- Up to one issue, one response and one retire per cycle, all concurrent.

## Test plan
- Single op: issue rd=5 (tag 0); response tag 0, result 0x3FF0000000000000, status 0 → next cycle wb_valid_o=1, rd=5, result matches; busy_o falls after retire.
- Out of order: issue rd=5 (tag 0), rd=6 (tag 1); respond tag 1 first, then tag 0 three cycles later → wb order rd 5 then 6; no wb before tag 0 returns.
- Full: with Depth=4, four issues without responses → req_ready_o=0 and fpu_valid_o=0 on the fifth; same-cycle retire does not admit it; admitted the cycle after.
- Backpressure and wrap: wb_ready_i=0 for 5 cycles → wb outputs stable. Then 10 ops → tags wrap 0..3,0..; order preserved.
- Flush: 3 ops in flight, flush_i pulse with a response in the same cycle → fpu_flush_o=1 that cycle; next cycle busy_o=0, no wb; a new issue gets tag 0.
- Bogus tag: response tag 2 with no entry allocated → err_o=1 and stays 1 through a flush; cleared only by rst_i.
